// File: rtl/ads8684_ctrl_pkg.sv
// Shared constants, state encodings and frame builder for the ADS8684 SPI controller.
package ads8684_ctrl_pkg;

  localparam logic [15:0] ADS8684_CMD_MAN_CH = 16'hC000;
  localparam logic [15:0] ADS8684_CMD_NOOP   = 16'h0000;
  localparam int          ADS8684_CH_SHIFT   = 10;
  localparam int          ADS8684_FRAME_BITS = 32;

  // Request/pipeline FSM states in the top.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } ctrl_state_t;

  // Serial engine states: csn setup, sclk high/low phases, csn hold.
  typedef enum logic [2:0] {
    SH_IDLE,
    SH_SETUP,
    SH_HIGH,
    SH_LOW,
    SH_HOLD
  } shift_state_t;

  // 32-bit frame: command in the upper half, zeros in the lower half.
  function automatic logic [31:0] build_frame(input logic is_cmd, input logic [1:0] ch);
    logic [15:0] cmd;
    cmd = is_cmd ? (ADS8684_CMD_MAN_CH | (16'(ch) << ADS8684_CH_SHIFT)) : ADS8684_CMD_NOOP;
    return {cmd, 16'h0000};
  endfunction

endpackage

// File: rtl/ads8684_ctrl_spi_shift.sv
// Serial engine: one full 32-bit MSB-first frame per start, with csn setup/hold
// spacing and sclk generated from a clk divider. sdi is driven and sdo captured
// on the clk edge that raises sclk; the ADC works on the falling edge.
module ads8684_spi_shift
  import ads8684_ctrl_pkg::*;
#(
  parameter int SCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] tx_word,
  output logic        done,
  output logic [31:0] rx_word,
  output logic        csn,
  output logic        sclk,
  output logic        sdi,
  input  logic        sdo
);

  localparam int DIV_W = $clog2(SCLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);

  shift_state_t     sh_state;
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       bit_idx;
  logic [4:0]       bit_nxt;
  logic [31:0]      tx_sr;
  logic [31:0]      rx_sr;
  logic             div_last;
  logic             load;
  logic             rise_first;
  logic             rise_next;

  assign div_last   = (div_cnt == DIV_LAST);
  assign bit_nxt    = bit_idx - 5'd1;
  assign load       = (sh_state == SH_IDLE) && start;
  assign rise_first = (sh_state == SH_SETUP) && div_last;
  assign rise_next  = (sh_state == SH_LOW) && div_last && (bit_idx != 5'd0);
  // done is asserted in the cycle whose closing edge raises csn, so the top can
  // register its result on exactly that edge.
  assign done       = (sh_state == SH_HOLD) && div_last;
  assign rx_word    = rx_sr;

  // Control sequencing: divider, bit counter and pin generation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_state <= SH_IDLE;
      div_cnt  <= '0;
      bit_idx  <= 5'd31;
      csn      <= 1'b1;
      sclk     <= 1'b0;
      sdi      <= 1'b0;
    end else begin
      case (sh_state)
        SH_IDLE: begin
          if (start) begin
            csn      <= 1'b0;
            div_cnt  <= '0;
            bit_idx  <= 5'd31;
            sh_state <= SH_SETUP;
          end
        end
        SH_SETUP: begin
          if (div_last) begin
            sclk     <= 1'b1;
            sdi      <= tx_sr[31];
            div_cnt  <= '0;
            sh_state <= SH_HIGH;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SH_HIGH: begin
          if (div_last) begin
            sclk     <= 1'b0;
            div_cnt  <= '0;
            sh_state <= SH_LOW;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SH_LOW: begin
          if (div_last) begin
            div_cnt <= '0;
            if (bit_idx == 5'd0) begin
              // sdi is only released after the ADC has sampled the last bit.
              sdi      <= 1'b0;
              sh_state <= SH_HOLD;
            end else begin
              sclk     <= 1'b1;
              sdi      <= tx_sr[bit_nxt];
              bit_idx  <= bit_nxt;
              sh_state <= SH_HIGH;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SH_HOLD: begin
          if (div_last) begin
            csn      <= 1'b1;
            div_cnt  <= '0;
            sh_state <= SH_IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: sh_state <= SH_IDLE;
      endcase
    end
  end

  // Data shift registers: latch the tx word at start, capture sdo on each sclk rise.
  always_ff @(posedge clk) begin
    if (load) tx_sr <= tx_word;
    if (rise_first) rx_sr[31] <= sdo;
    else if (rise_next) rx_sr[bit_nxt] <= sdo;
  end

endmodule

// File: rtl/ads8684_ctrl.sv
// ADS8684 SPI master: accepts channel requests, issues one 32-bit frame per
// request (or a NO_OP to flush), and returns each result one frame later,
// tagged with its channel.
module ads8684_ctrl
  import ads8684_ctrl_pkg::*;
#(
  parameter int SCLK_DIV = 4,
  parameter int CSN_GAP  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_ch,
  output logic        rd_valid,
  output logic [1:0]  rd_ch,
  output logic [15:0] rd_data,
  output logic        busy,
  output logic        csn,
  output logic        sclk,
  output logic        sdi,
  input  logic        sdo
);

  localparam int GAP_W = $clog2(CSN_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CSN_GAP - 1);

  ctrl_state_t      state;
  logic [GAP_W-1:0] gap_cnt;
  logic             pend_valid;
  logic [1:0]       pend_ch;
  logic             cur_cmd;
  logic [1:0]       cur_ch;
  logic             accept;
  logic             start;
  logic             frame_done;
  logic [31:0]      tx_word;
  logic [31:0]      rx_word;

  // req_ready is only high in IDLE, so it doubles as the IDLE qualifier here.
  // A waiting request always beats the NO_OP flush.
  assign accept  = req_valid && req_ready;
  assign start   = req_ready && (req_valid || pend_valid);
  assign tx_word = build_frame(accept, req_ch);

  ads8684_spi_shift #(
    .SCLK_DIV(SCLK_DIV)
  ) u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .tx_word (tx_word),
    .done    (frame_done),
    .rx_word (rx_word),
    .csn     (csn),
    .sclk    (sclk),
    .sdi     (sdi),
    .sdo     (sdo)
  );

  // Request/pipeline FSM with registered handshake, result and busy outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_GAP;
      gap_cnt    <= '0;
      req_ready  <= 1'b0;
      rd_valid   <= 1'b0;
      rd_ch      <= 2'd0;
      rd_data    <= 16'h0000;
      busy       <= 1'b0;
      pend_valid <= 1'b0;
      pend_ch    <= 2'd0;
      cur_cmd    <= 1'b0;
      cur_ch     <= 2'd0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cur_cmd   <= 1'b1;
            cur_ch    <= req_ch;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_SETUP;
          end else if (pend_valid) begin
            cur_cmd   <= 1'b0;
            cur_ch    <= 2'd0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_SETUP;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_SETUP: begin
          busy  <= 1'b1;
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          busy <= 1'b1;
          if (frame_done) begin
            // The upper half of this frame's rx word answers the previous command.
            if (pend_valid) begin
              rd_valid <= 1'b1;
              rd_ch    <= pend_ch;
              rd_data  <= rx_word[31:16];
            end
            pend_valid <= cur_cmd;
            pend_ch    <= cur_ch;
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          busy    <= 1'b1;
          gap_cnt <= '0;
          state   <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            req_ready <= 1'b1;
            busy      <= pend_valid;
            state     <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
            busy    <= 1'b1;
          end
        end
        default: state <= ST_GAP;
      endcase
    end
  end

endmodule
